// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: machine word, RAM handshake state and RAM arbiter FSM states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_t;

endpackage

// File: rtl/arb_watchdog.sv
// Grant watchdog: counts granted cycles without ACCESS and aborts a grant that hangs.
module arb_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic access,
  output logic expire,
  output logic timeout
);
  localparam int unsigned WDW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  logic [WDW-1:0] wd_cnt;

  // The arbiter always passes through IDLE between grants, so !active doubles as grant-entry clear.
  assign expire = (TIMEOUT_CYC != 0) && active && !access && (wd_cnt == WDW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= expire;
      if (!active || access) wd_cnt <= '0;
      else                   wd_cnt <= wd_cnt + WDW'(1);
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates the single RAM port between instruction fetch and data access; data wins,
// fetch is forced after STARVE_MAX consecutive data grants while it waits.
module ram_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned STARVE_MAX  = 4,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        timeout
);
  arb_state_t state, next_state;
  ramstate_t  rs;
  logic [3:0] starve_cnt;
  logic       d_req, starved, granted, access, wd_expire, i_done, d_done;

  assign rs      = ramstate_t'(ramstate);
  assign d_req   = dREN | dWEN;
  assign starved = iREN && (starve_cnt == 4'(STARVE_MAX));
  assign granted = (state != IDLE);
  assign access  = (rs == ACCESS);
  assign i_done  = (state == GNT_I) && access && iREN;
  assign d_done  = (state == GNT_D) && access && d_req;

  assign iload = ramload;
  assign dload = ramload;
  assign iwait = iREN  & ~((state == GNT_I) & access);
  assign dwait = d_req & ~((state == GNT_D) & access);

  arb_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_watchdog (
    .clk    (CLK),
    .rst    (RST),
    .active (granted),
    .access (access),
    .expire (wd_expire),
    .timeout(timeout)
  );

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    unique case (state)
      IDLE: begin
        if (d_req && !starved) next_state = GNT_D;
        else if (iREN)         next_state = GNT_I;
      end
      GNT_I: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        if (!iREN || access || rs == ERROR || wd_expire) next_state = IDLE;
      end
      GNT_D: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        if (!d_req || access || rs == ERROR || wd_expire) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Only completed accesses move the counter; aborts, errors and timeouts leave it alone.
  always_ff @(posedge CLK) begin
    if (RST)                           starve_cnt <= '0;
    else if (i_done)                   starve_cnt <= '0;
    else if (state == IDLE && !iREN)   starve_cnt <= '0;
    else if (d_done && iREN && starve_cnt != 4'(STARVE_MAX))
                                       starve_cnt <= starve_cnt + 4'd1;
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter (STARVE_MAX=4, TIMEOUT_CYC=64).
module tb_ram_arbiter;
  logic        CLK, RST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN, timeout;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int unsigned errors = 0;
  int unsigned checks = 0;

  localparam logic [1:0] RS_FREE = 2'd0, RS_BUSY = 2'd1, RS_ACCESS = 2'd2, RS_ERROR = 2'd3;

  ram_arbiter #(
    .STARVE_MAX (4),
    .TIMEOUT_CYC(64)
  ) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .timeout(timeout)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    RST = 1'b1; iREN = 0; dREN = 0; dWEN = 0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = RS_FREE;
    tick(); tick();
    RST = 1'b0;
    settle();

    // reset / idle
    chk("rst_ramREN", 32'(ramREN), 0);
    chk("rst_ramWEN", 32'(ramWEN), 0);
    chk("rst_iwait", 32'(iwait), 0);
    chk("rst_dwait", 32'(dwait), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_ramaddr", ramaddr, 0);

    // fetch, ACCESS on 2nd granted cycle
    iREN = 1; iaddr = 32'h40; settle();
    chk("f_c0_ramREN", 32'(ramREN), 0);
    chk("f_c0_iwait", 32'(iwait), 1);
    tick(); ramstate = RS_BUSY; settle();
    chk("f_c1_ramREN", 32'(ramREN), 1);
    chk("f_c1_ramaddr", ramaddr, 32'h40);
    chk("f_c1_iwait", 32'(iwait), 1);
    tick(); ramstate = RS_ACCESS; ramload = 32'hDEADBEEF; settle();
    chk("f_c2_iwait", 32'(iwait), 0);
    chk("f_c2_iload", iload, 32'hDEADBEEF);
    chk("f_c2_ramREN", 32'(ramREN), 1);
    tick(); ramstate = RS_FREE; settle();
    chk("f_bubble_ramREN", 32'(ramREN), 0);
    chk("f_bubble_iwait", 32'(iwait), 1);
    tick(); iREN = 0; settle();
    chk("f_drop_ramREN", 32'(ramREN), 0);
    tick(); settle();

    // simultaneous fetch + data write: data first
    iREN = 1; iaddr = 32'h44; dWEN = 1; daddr = 32'h100; dstore = 32'h12345678; settle();
    chk("p_c0_ramWEN", 32'(ramWEN), 0);
    chk("p_c0_dwait", 32'(dwait), 1);
    tick(); ramstate = RS_BUSY; settle();
    chk("p_c1_ramWEN", 32'(ramWEN), 1);
    chk("p_c1_ramREN", 32'(ramREN), 0);
    chk("p_c1_ramaddr", ramaddr, 32'h100);
    chk("p_c1_ramstore", ramstore, 32'h12345678);
    chk("p_c1_iwait", 32'(iwait), 1);
    tick(); ramstate = RS_ACCESS; settle();
    chk("p_c2_dwait", 32'(dwait), 0);
    chk("p_c2_iwait", 32'(iwait), 1);
    tick(); dWEN = 0; ramstate = RS_FREE; settle();
    chk("p_bubble_ramWEN", 32'(ramWEN), 0);
    chk("p_bubble_ramREN", 32'(ramREN), 0);
    tick(); ramstate = RS_BUSY; settle();
    chk("p_fetch_ramREN", 32'(ramREN), 1);
    chk("p_fetch_ramaddr", ramaddr, 32'h44);
    chk("p_fetch_ramstore", ramstore, 0);
    tick(); ramstate = RS_ACCESS; ramload = 32'hCAFEF00D; settle();
    chk("p_fetch_iwait", 32'(iwait), 0);
    chk("p_fetch_iload", iload, 32'hCAFEF00D);
    tick(); iREN = 0; ramstate = RS_FREE; settle();
    tick(); settle();

    // starvation bound: 4 data grants, then fetch
    iREN = 1; iaddr = 32'h80; dREN = 1; daddr = 32'h200;
    for (int k = 0; k < 4; k++) begin
      ramstate = RS_FREE; settle();
      chk("s_bubble_ramREN", 32'(ramREN), 0);
      tick(); ramstate = RS_ACCESS; settle();
      chk("s_data_ramaddr", ramaddr, 32'h200);
      chk("s_data_ramREN", 32'(ramREN), 1);
      chk("s_data_dwait", 32'(dwait), 0);
      chk("s_data_iwait", 32'(iwait), 1);
      tick();
    end
    ramstate = RS_FREE; settle();
    tick(); ramstate = RS_BUSY; settle();
    chk("s_forced_ramaddr", ramaddr, 32'h80);
    chk("s_forced_ramREN", 32'(ramREN), 1);
    chk("s_forced_dwait", 32'(dwait), 1);
    tick(); ramstate = RS_ACCESS; settle();
    chk("s_forced_iwait", 32'(iwait), 0);
    tick(); ramstate = RS_FREE; settle();
    tick(); ramstate = RS_BUSY; settle();
    chk("s_after_ramaddr", ramaddr, 32'h200);
    tick(); ramstate = RS_ACCESS; settle();
    chk("s_after_dwait", 32'(dwait), 0);
    tick(); iREN = 0; dREN = 0; ramstate = RS_FREE; settle();
    tick(); settle();

    // watchdog: 64 BUSY grant cycles
    dREN = 1; daddr = 32'h300; ramstate = RS_BUSY; settle();
    chk("w_idle_ramREN", 32'(ramREN), 0);
    for (int g = 1; g <= 64; g++) begin
      tick();
      chk("w_grant_ramREN", 32'(ramREN), 1);
      chk("w_grant_timeout", 32'(timeout), 0);
    end
    tick(); settle();
    chk("w_abort_timeout", 32'(timeout), 1);
    chk("w_abort_ramREN", 32'(ramREN), 0);
    chk("w_abort_dwait", 32'(dwait), 1);
    tick(); settle();
    chk("w_regrant_timeout", 32'(timeout), 0);
    chk("w_regrant_ramREN", 32'(ramREN), 1);
    ramstate = RS_ACCESS; settle();
    chk("w_regrant_dwait", 32'(dwait), 0);
    tick(); dREN = 0; ramstate = RS_FREE; settle();
    tick(); settle();

    // ERROR during fetch grant: retry
    iREN = 1; iaddr = 32'h500; settle();
    tick(); ramstate = RS_ERROR; settle();
    chk("e_grant_ramREN", 32'(ramREN), 1);
    chk("e_grant_iwait", 32'(iwait), 1);
    tick(); ramstate = RS_FREE; settle();
    chk("e_idle_ramREN", 32'(ramREN), 0);
    chk("e_idle_iwait", 32'(iwait), 1);
    tick(); ramstate = RS_BUSY; settle();
    chk("e_retry_ramREN", 32'(ramREN), 1);
    chk("e_retry_ramaddr", ramaddr, 32'h500);
    tick(); ramstate = RS_ACCESS; settle();
    chk("e_retry_iwait", 32'(iwait), 0);
    tick(); iREN = 0; ramstate = RS_FREE; settle();
    tick(); settle();

    // data requester drops mid-grant
    dREN = 1; daddr = 32'h600; settle();
    tick(); ramstate = RS_BUSY; settle();
    chk("d_grant_ramREN", 32'(ramREN), 1);
    dREN = 0; settle();
    chk("d_drop_ramREN", 32'(ramREN), 0);
    chk("d_drop_dwait", 32'(dwait), 0);
    tick(); dREN = 1; settle();
    chk("d_idle_ramREN", 32'(ramREN), 0);
    tick(); settle();
    chk("d_regrant_ramREN", 32'(ramREN), 1);

    // reset mid-grant
    RST = 1; tick(); settle();
    chk("r_mid_ramREN", 32'(ramREN), 0);
    chk("r_mid_dwait", 32'(dwait), 1);
    chk("r_mid_timeout", 32'(timeout), 0);
    RST = 0; dREN = 0; ramstate = RS_FREE;
    tick(); settle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
